// File: rtl/grid_axil_pkg.sv
// Shared types, constants and helpers for the grid controller AXI4-Lite register slave.
package grid_axil_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned REG_IDX_W = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // One register-file write: target slot, data and byte enables
    typedef struct packed {
        logic [REG_IDX_W-1:0] idx;
        logic [DATA_W-1:0]    data;
        logic [STRB_W-1:0]    strb;
    } reg_wr_t;

    function automatic logic [DATA_W-1:0] byte_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/grid_axil_regfile.sv
// Four 32-bit control registers with a byte-masked write port, async read port and
// a one-cycle per-register update strobe.
module grid_axil_regfile
    import grid_axil_pkg::*;
(
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             wr_en_i,
    input  reg_wr_t                          wr_i,
    input  logic [REG_IDX_W-1:0]             rd_idx_i,
    output logic [DATA_W-1:0]                rd_data_c_o,
    output logic [NUM_REGS-1:0][DATA_W-1:0]  regs_o,
    output logic [NUM_REGS-1:0]              wr_pulse_o
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             pulse_q, pulse_d;
    logic [DATA_W-1:0]               mask;

    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        mask    = byte_mask(wr_i.strb);
        if (wr_en_i) begin
            regs_d[wr_i.idx]  = (regs_q[wr_i.idx] & ~mask) | (wr_i.data & mask);
            pulse_d[wr_i.idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q  <= '0;
            pulse_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
        end
    end

    assign rd_data_c_o = regs_q[rd_idx_i];
    assign regs_o      = regs_q;
    assign wr_pulse_o  = pulse_q;

endmodule

// File: rtl/grid_ctrl_axil_slave.sv
// AXI4-Lite slave for the grid controller register bank: independent write and read FSMs.
// Define GRID_AXIL_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module grid_ctrl_axil_slave
    import grid_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                                    ACLK,
    input  logic                                    ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           AWADDR,
    input  logic [2:0]                              AWPROT,
    input  logic                                    AWVALID,
    output logic                                    AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]           WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]         WSTRB,
    input  logic                                    WVALID,
    output logic                                    WREADY,
    output logic [1:0]                              BRESP,
    output logic                                    BVALID,
    input  logic                                    BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           ARADDR,
    input  logic [2:0]                              ARPROT,
    input  logic                                    ARVALID,
    output logic                                    ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]           RDATA,
    output logic [1:0]                              RRESP,
    output logic                                    RVALID,
    input  logic                                    RREADY,
    output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] slv_reg,
    output logic [NUM_REGS-1:0]                     reg_wr_pulse
);

    localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;

`ifdef GRID_AXIL_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    function automatic logic is_mapped(input logic [IDX_W-1:0] idx);
        return idx < IDX_W'(NUM_REGS);
    endfunction

    // Write channel state
    wr_state_e          wr_state_q, wr_state_d;
    logic               awready_q, awready_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic [IDX_W-1:0]   awidx_q, awidx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;

    // Read channel state
    rd_state_e          rd_state_q, rd_state_d;
    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               aw_hs_c, w_hs_c, ar_hs_c;
    logic [IDX_W-1:0]   aw_idx_c, ar_idx_c;
    logic               commit_c;
    logic [IDX_W-1:0]   cm_idx_c;
    logic [DATA_W-1:0]  cm_data_c;
    logic [STRB_W-1:0]  cm_strb_c;
    logic               wr_en_c;
    reg_wr_t            wr_c;
    logic [DATA_W-1:0]  rd_data_c;
    logic               unused_c;

    assign aw_hs_c  = AWVALID && awready_q;
    assign w_hs_c   = WVALID && wready_q;
    assign ar_hs_c  = ARVALID && arready_q;
    assign aw_idx_c = AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx_c = ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_c = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    // Write FSM: collect address and data in either order, then commit and respond
    always_comb begin
        wr_state_d = wr_state_q;
        awidx_d    = awidx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        commit_c   = 1'b0;
        cm_idx_c   = awidx_q;
        cm_data_c  = wdata_q;
        cm_strb_c  = wstrb_q;

        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    commit_c  = 1'b1;
                    cm_idx_c  = aw_idx_c;
                    cm_data_c = WDATA;
                    cm_strb_c = WSTRB;
                end else if (aw_hs_c) begin
                    awidx_d    = aw_idx_c;
                    wr_state_d = W_HAVE_ADDR;
                end else if (w_hs_c) begin
                    wdata_d    = WDATA;
                    wstrb_d    = WSTRB;
                    wr_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs_c) begin
                    commit_c  = 1'b1;
                    cm_data_c = WDATA;
                    cm_strb_c = WSTRB;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs_c) begin
                    commit_c = 1'b1;
                    cm_idx_c = aw_idx_c;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        if (commit_c) begin
            wr_state_d = W_RESP;
            bvalid_d   = 1'b1;
            bresp_d    = (SLVERR_EN && !is_mapped(cm_idx_c)) ? RESP_SLVERR : RESP_OKAY;
        end

        awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_DATA);
        wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_ADDR);
    end

    assign wr_en_c   = commit_c && is_mapped(cm_idx_c);
    assign wr_c.idx  = cm_idx_c[REG_IDX_W-1:0];
    assign wr_c.data = cm_data_c;
    assign wr_c.strb = cm_strb_c;

    // Read FSM: capture on AR handshake, hold until RREADY
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_c) begin
                    rd_state_d = R_DATA;
                    rvalid_d   = 1'b1;
                    rdata_d    = is_mapped(ar_idx_c) ? rd_data_c : '0;
                    rresp_d    = (SLVERR_EN && !is_mapped(ar_idx_c)) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        arready_d = (rd_state_d == R_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    grid_axil_regfile u_regfile (
        .clk_i       (ACLK),
        .rst_ni      (ARESETN),
        .wr_en_i     (wr_en_c),
        .wr_i        (wr_c),
        .rd_idx_i    (ar_idx_c[REG_IDX_W-1:0]),
        .rd_data_c_o (rd_data_c),
        .regs_o      (slv_reg),
        .wr_pulse_o  (reg_wr_pulse)
    );

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

endmodule

// File: doc/grid_ctrl_axil_slave.md
# grid_ctrl_axil_slave

AXI4-Lite responder for the grid controller's register bank. It accepts single-beat writes and reads from the VIP master or the PS interconnect and holds four 32-bit control registers. It drives those registers, plus one-cycle write strobes, into the 2D grid datapath. It is the slave end of the S00_AXI interface that the block-design bench exercises.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte-address width; 16 word slots, of which 0x0–0xC are mapped.
- ACLK  in  1  single clock; all logic is rising-edge.
- ARESETN  in  1  asynchronous, active-low reset. Assertion is asynchronous; release is sampled on ACLK.
- AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- AWPROT  in  3  ignored.
- AWVALID / AWREADY  in / out  1  write-address handshake.
- WDATA  in  32  write data.
- WSTRB  in  4  byte lane enables.
- WVALID / WREADY  in / out  1  write-data handshake.
- BRESP  out  2  write response.
- BVALID / BREADY  out / in  1  write-response handshake.
- ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- ARPROT  in  3  ignored.
- ARVALID / ARREADY  in / out  1  read-address handshake.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID / RREADY  out / in  1  read-data handshake.
- slv_reg  out  4x32  current register contents, index = AWADDR[3:2].
- reg_wr_pulse  out  4  one-cycle strobe, bit n high in the cycle after register n is updated.

## Operation
- Address decode uses ADDR[C_S_AXI_ADDR_WIDTH-1:2]. AXI address bits [1:0] are ignored.
- Write FSM states:
  - W_IDLE: AWREADY=WREADY=1.
  - AW handshake alone → W_HAVE_ADDR: latch the address, drop AWREADY.
  - W handshake alone → W_HAVE_DATA: latch data and strobe, drop WREADY.
  - Both handshakes in the same cycle → commit.
  - From W_HAVE_ADDR or W_HAVE_DATA, the missing handshake → commit.
  - Commit: apply byte-masked update `reg = (reg & ~mask) | (WDATA & mask)`, where mask expands WSTRB per byte. Set BVALID, go to W_RESP.
  - W_RESP: AWREADY=WREADY=0. BVALID holds until BREADY, then return to W_IDLE.
- Read FSM states:
  - R_IDLE: ARREADY=1. On handshake, latch RDATA from the register file and go to R_DATA.
  - R_DATA: ARREADY=0. RVALID holds with stable RDATA/RRESP until RREADY, then return to R_IDLE.
- Read and write channels are fully independent and may be active at the same time.
- A read and a write commit to the same register on the same edge: RDATA returns the pre-write value.
- Only OKAY (2'b00) or SLVERR (2'b10) is ever returned.

## Timing
- Reset values, set while ARESETN=0:
  - All READY and VALID outputs = 0.
  - BRESP = RRESP = 0, RDATA = 0.
  - slv_reg = 0, reg_wr_pulse = 0.
- AWREADY, WREADY and ARREADY rise on the first ACLK edge after ARESETN releases.
- Write latency: BVALID rises the edge after the last of the AW/W handshakes. slv_reg updates on that same edge, and reg_wr_pulse is high for exactly that one cycle.
- Read latency: RVALID rises the edge after the AR handshake.
- Throughput:
  - One write per 2 cycles minimum when BREADY is held high.
  - One read per 2 cycles minimum when RREADY is held high.
- No combinational path from any input to any READY or VALID output.
- Reset asserted mid-transaction: every pending address, data and response is discarded and registers clear. No response is issued for the aborted transaction.

## Configuration
- GRID_AXIL_SLVERR_EN defined:
  - Writes to unmapped words (index ≥ 4) leave all registers unchanged, produce no strobe, and return BRESP=SLVERR.
  - Reads from unmapped words return RDATA=0, RRESP=SLVERR.
- GRID_AXIL_SLVERR_EN undefined:
  - Unmapped writes are silently dropped with BRESP=OKAY.
  - Unmapped reads return 0 with RRESP=OKAY.

## Structure
- Shared package `grid_axil_pkg` holds:
  - RESP_OKAY and RESP_SLVERR constants.
  - NUM_REGS = 4.
  - Write-state and read-state enum typedefs.
  - Byte-mask expansion function.
- One sub-module, `grid_axil_regfile`: register storage with a byte-masked write port, an asynchronous read port and the strobe generator. The top level holds both FSMs.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read them back → each read returns the written value with RRESP=OKAY, and every BRESP=OKAY.
- Register 1 holds 0x00000002; write 0xAABBCCDD to 0x4 with WSTRB=4'b0010 → readback is 0x0000CC02, and reg_wr_pulse=4'b0010 for one cycle.
- Present W three cycles before AW to 0x8 → WREADY drops after the W handshake, BVALID rises one cycle after the AW handshake, and slv_reg[2] updates on that edge.
- Hold BREADY low for 5 cycles after a write → BVALID stays high, AWREADY/WREADY stay 0, and a queued second write is not committed until BREADY.
- Write 0xDEAD to 0x20, then read 0x20 → with the macro: BRESP=2'b10, RDATA=0, RRESP=2'b10, registers unchanged. Without the macro: both responses are OKAY.
- Assert ARESETN low while BVALID=1 → BVALID=0 and all slv_reg=0 immediately. After release, a read of 0x0 returns 0.
